// File: rtl/hs_pkg.sv
// hs_pkg: shared constants and helpers for the hs_fifo elastic buffer.
//   REQ_MARGIN : free slots kept in reserve when raising req_l. It absorbs
//                the registered req_l plus the source's one-cycle req->ack lag.
//   ptr_empty / ptr_full : compare two wrap-bit pointers (zero-extended to 32).
package hs_pkg;

   localparam int REQ_MARGIN = 2;

   function automatic logic ptr_empty(input logic [31:0] wr, input logic [31:0] rd);
      return wr == rd;
   endfunction

   // Full when the pointers differ only in the wrap bit (bit aw).
   function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd,
                                     input int aw);
      return (wr ^ rd) == (32'd1 << aw);
   endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// hs_fifo_mem: depth x data_width register array for hs_fifo.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (combinational read)
//   rdata_o : word at raddr_i
// Contents are not reset.
module hs_fifo_mem #(
   parameter int data_width = 32,
   parameter int depth      = 8,
   parameter int addr_width = 3
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [addr_width-1:0] waddr_i,
   input  logic [data_width-1:0] wdata_i,
   input  logic [addr_width-1:0] raddr_i,
   output logic [data_width-1:0] rdata_o
);

   logic [data_width-1:0] mem_q [depth];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_fifo.sv
// hs_fifo: elastic buffer between a req/ack pull source and a pull consumer.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   req_l    : registered request to the upstream source
//   ack_l    : upstream one-cycle ack, din valid with it
//   din      : upstream data
//   req_r    : downstream request
//   ack_r    : registered one-cycle ack pulse to downstream
//   dout     : head word, valid at ack_r and held until the next ack_r
//   overflow : sticky, set when ack_l arrives while full
// Optional (HS_FIFO_LEVEL_EN defined):
//   level     : current occupancy
//   max_level : sticky occupancy high-watermark
module hs_fifo
   import hs_pkg::*;
#(
   parameter int data_width = 32,
   parameter int depth      = 8,
   parameter int addr_width = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  req_l,
   input  logic                  ack_l,
   input  logic [data_width-1:0] din,
   input  logic                  req_r,
   output logic                  ack_r,
   output logic [data_width-1:0] dout,
   output logic                  overflow
`ifdef HS_FIFO_LEVEL_EN
   ,
   output logic [addr_width:0]   level,
   output logic [addr_width:0]   max_level
`endif
);

   localparam logic [addr_width:0] REQ_THRESH = (addr_width+1)'(depth - REQ_MARGIN);

   logic [addr_width:0]   wr_ptr_q, rd_ptr_q;
   logic [addr_width:0]   occ, occ_next;
   logic                  full, empty, push, pop;
   logic                  req_l_q, ack_r_q, overflow_q;
   logic [data_width-1:0] dout_q, rd_data;

   assign full  = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), addr_width);
   assign empty = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q));

   // Writes are gated by rst so nothing lands in storage while held in reset.
   assign push = ack_l & ~full & rst;
   // ack_r_q blocks back-to-back acks: the consumer drops req_r a cycle late.
   // A word pushed this edge is not yet visible here (no bypass).
   assign pop  = req_r & ~ack_r_q & ~empty;

   assign occ      = wr_ptr_q - rd_ptr_q;
   assign occ_next = occ + {{addr_width{1'b0}}, push} - {{addr_width{1'b0}}, pop};

   hs_fifo_mem #(
      .data_width (data_width),
      .depth      (depth),
      .addr_width (addr_width)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q[addr_width-1:0]),
      .wdata_i (din),
      .raddr_i (rd_ptr_q[addr_width-1:0]),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         req_l_q    <= 1'b0;
         ack_r_q    <= 1'b0;
         dout_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            dout_q   <= rd_data;
         end
         ack_r_q <= pop;
         req_l_q <= (occ_next <= REQ_THRESH);
         if (ack_l && full) overflow_q <= 1'b1;
      end
   end

   assign req_l    = req_l_q;
   assign ack_r    = ack_r_q;
   assign dout     = dout_q;
   assign overflow = overflow_q;

`ifdef HS_FIFO_LEVEL_EN
   logic [addr_width:0] max_level_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     max_level_q <= '0;
      else if (occ_next > max_level_q) max_level_q <= occ_next;
   end

   assign level     = occ;
   assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_hs_fifo.sv
module tb_hs_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ack_l = 1'b0;
   logic          req_r = 1'b0;
   logic [DW-1:0] din = '0;
   logic          req_l, ack_r, overflow;
   logic [DW-1:0] dout;
`ifdef HS_FIFO_LEVEL_EN
   logic [AW:0]   level, max_level;
`endif

   always #5 clk = ~clk;

   hs_fifo #(.data_width(DW), .depth(DEPTH), .addr_width(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_l    (req_l),
      .ack_l    (ack_l),
      .din      (din),
      .req_r    (req_r),
      .ack_r    (ack_r),
      .dout     (dout),
      .overflow (overflow)
`ifdef HS_FIFO_LEVEL_EN
      ,
      .level     (level),
      .max_level (max_level)
`endif
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   // Reference model: a queue of stored words plus expected registered outputs.
   logic [DW-1:0] q[$];
   bit            m_ack, m_req, m_ovf;
   logic [DW-1:0] m_dout;
   int            m_max;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ack  = 1'b0;
      m_req  = 1'b0;
      m_ovf  = 1'b0;
      m_dout = '0;
      m_max  = 0;
   endtask

   // One clock: drive inputs at negedge, advance the model, check after the edge.
   task automatic step(input logic al, input logic [DW-1:0] d, input logic rr);
      bit full, pop;
      @(negedge clk);
      ack_l = al; din = d; req_r = rr;
      full = (q.size() == DEPTH);
      pop  = rr && !m_ack && (q.size() != 0);
      if (al && full) m_ovf = 1'b1;
      if (pop) m_dout = q.pop_front();
      if (al && !full) q.push_back(d);
      m_ack = pop;
      m_req = (q.size() <= DEPTH - 2);
      if (q.size() > m_max) m_max = q.size();
      @(posedge clk); #1;
      chk("ack_r", ack_r, m_ack);
      chk("dout", dout, m_dout);
      chk("req_l", req_l, m_req);
      chk("overflow", overflow, m_ovf);
`ifdef HS_FIFO_LEVEL_EN
      chk("level", level, q.size());
      chk("max_level", max_level, m_max);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pcnt, seq, last, guard, target;

      // 1: held in reset with both sides active
      ack_l = 1'b1; req_r = 1'b1; din = 32'h55;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_l", req_l, 1'b0);
      chk("rst_ack_r", ack_r, 1'b0);
      chk("rst_dout", dout, '0);
      chk("rst_overflow", overflow, 1'b0);
      @(negedge clk);
      ack_l = 1'b0; rst = 1'b1;
      model_reset();
      step(1'b0, '0, 1'b1);   // nothing was written during reset
      step(1'b0, '0, 1'b1);

      // 2: single push into empty FIFO, latency
      step(1'b1, 32'h2A, 1'b1);
      chk("t2_ack_t", ack_r, 1'b0);
      step(1'b0, '0, 1'b1);
      chk("t2_ack_t1", ack_r, 1'b1);
      chk("t2_dout", dout, 32'h2A);
      step(1'b0, '0, 1'b1);
      chk("t2_ack_t2", ack_r, 1'b0);

      // 3: fill with consumer idle, then drain in order
      pcnt = 0;
      for (int i = 0; i < 40; i++) begin
         logic al;
         al = req_l;
         step(al, pcnt, 1'b0);
         if (al) pcnt++;
      end
      chk("t3_req_l_low", req_l, 1'b0);
      chk("t3_stored", pcnt, DEPTH - 1);
      seq = 0; guard = 0;
      while (seq < pcnt && guard < 100) begin
         step(1'b0, '0, 1'b1);
         if (ack_r) begin
            chk("t3_order", dout, seq);
            seq++;
         end
         guard++;
      end
      chk("t3_drained", seq, pcnt);

      // 4: full-rate streaming, 1000 words
      pcnt = 0; seq = 0; last = 0; guard = 0;
      while (seq < 1000 && guard < 3000) begin
         logic al;
         al = req_l && (pcnt < 1000);
         step(al, 32'(pcnt), 1'b1);
         if (al) pcnt++;
         if (ack_r) begin
            chk("t4_order", dout, seq);
            if (seq >= 4) chk("t4_spacing", cyc - last, 2);
            last = cyc;
            seq++;
         end
         guard++;
      end
      chk("t4_count", seq, 1000);

      // 5: random stalls on both sides across pointer wrap
      target = 3 * DEPTH + 5;
      pcnt = 0; seq = 0; guard = 0;
      while (seq < target && guard < 2000) begin
         logic al, rr;
         al = req_l && (pcnt < target) && ($urandom_range(99) >= 30);
         rr = ($urandom_range(99) >= 50);
         step(al, 32'h1000 + pcnt, rr);
         if (al) pcnt++;
         if (ack_r) begin
            chk("t5_order", dout, 32'h1000 + seq);
            seq++;
         end
         guard++;
      end
      chk("t5_count", seq, target);
      chk("t5_overflow", overflow, 1'b0);

      // Overflow: source ignores req_l and pushes past full
      for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 32'h300 + i, 1'b0);
      chk("ovf_set", overflow, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("ovf_sticky", overflow, 1'b1);
      seq = 0; guard = 0;
      while (seq < 3 && guard < 20) begin
         step(1'b0, '0, 1'b1);
         if (ack_r) begin
            chk("ovf_order", dout, 32'h300 + seq);
            seq++;
         end
         guard++;
      end
      chk("ovf_pops", seq, 3);

      // 6: async reset mid-operation with 5 words buffered
      chk("t6_buffered", q.size(), 5);
      #2 rst = 1'b0;
      #1;
      chk("t6_req_l", req_l, 1'b0);
      chk("t6_ack_r", ack_r, 1'b0);
      chk("t6_dout", dout, '0);
      chk("t6_overflow", overflow, 1'b0);
      rst = 1'b1;
      model_reset();
      step(1'b1, 32'h400, 1'b0);
      step(1'b0, '0, 1'b1);
      chk("t6_first_ack", ack_r, 1'b1);
      chk("t6_first_word", dout, 32'h400);
      step(1'b0, '0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
